// File: rtl/ddr_init_seq_if.sv
// ddr_init_seq_if: control/status bundle between the DDR init sequencer and its
// surroundings.
//   slave  modport (sequencer): start, ddr_pll_lock, cfg_done in;
//                               reset/config/status outputs out.
//   master modport (environment): the mirror image.
interface ddr_init_seq_if;
    logic       start;
    logic       ddr_pll_lock;
    logic       cfg_done;
    logic       ddr_pll_rstn;
    logic       phy_rstn;
    logic       ctrl_rstn;
    logic       cfg_sel;
    logic       cfg_start;
    logic       cfg_reset;
    logic       axi_aresetn;
    logic       init_done;
    logic       init_error;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport slave (
        input  start, ddr_pll_lock, cfg_done,
        output ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset,
               axi_aresetn, init_done, init_error, state, retry_cnt
    );

    modport master (
        output start, ddr_pll_lock, cfg_done,
        input  ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset,
               axi_aresetn, init_done, init_error, state, retry_cnt
    );
endinterface

// File: rtl/ddr_init_seq.sv
// ddr_init_seq: power-up / recovery sequencer for the LPDDR4 hard controller.
// Walks PLL reset -> PLL lock -> config engine reset -> config run -> AXI reset
// release, retrying on lock/config timeouts and parking in FAIL when retries
// run out.
// Ports:
//   clk_100  sequencer clock
//   reset    asynchronous active-high reset
//   bus      ddr_init_seq_if.slave: start pulse, async lock/done inputs,
//            registered reset/config/status outputs, state and retry_cnt
module ddr_init_seq #(
    parameter int unsigned PLL_RST_CYC  = 64,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned CFG_RST_CYC  = 32,
    parameter int unsigned CFG_TIMEOUT  = 1000000,
    parameter int unsigned AXI_REL_CYC  = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter bit          AUTO_START   = 1'b1,
    parameter int unsigned CNT_W        = 24
) (
    input  logic          clk_100,
    input  logic          reset,
    ddr_init_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_RST  = 3'd1,
        PLL_WAIT = 3'd2,
        CFG_RST  = 3'd3,
        CFG_RUN  = 3'd4,
        AXI_REL  = 3'd5,
        READY    = 3'd6,
        FAIL     = 3'd7
    } state_t;

    // Terminal counts: a timed state ends on the cycle its counter reads N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CFG_RST_LAST = CNT_W'(CFG_RST_CYC - 1);
    localparam logic [CNT_W-1:0] CFG_LAST     = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AXI_LAST     = CNT_W'(AXI_REL_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       lock_sync, done_sync;
    logic             lock_s, done_s;
    logic             timeout;

    logic pll_rstn_q, phy_rstn_q, ctrl_rstn_q, cfg_sel_q, cfg_start_q;
    logic cfg_reset_q, axi_aresetn_q, init_done_q, init_error_q;
    logic pll_rstn_d, phy_rstn_d, ctrl_rstn_d, cfg_sel_d, cfg_start_d;
    logic cfg_reset_d, axi_aresetn_d, init_done_d, init_error_d;

    // Two-flop synchronizers for the asynchronous lock and config-done inputs.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            lock_sync <= '0;
            done_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], bus.ddr_pll_lock};
            done_sync <= {done_sync[0], bus.cfg_done};
        end
    end

    assign lock_s = lock_sync[1];
    assign done_s = done_sync[1];

    // State, counter, retry count and registered outputs.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rstn_q    <= 1'b0;
            phy_rstn_q    <= 1'b0;
            ctrl_rstn_q   <= 1'b0;
            cfg_sel_q     <= 1'b0;
            cfg_start_q   <= 1'b0;
            cfg_reset_q   <= 1'b0;
            axi_aresetn_q <= 1'b0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rstn_q    <= pll_rstn_d;
            phy_rstn_q    <= phy_rstn_d;
            ctrl_rstn_q   <= ctrl_rstn_d;
            cfg_sel_q     <= cfg_sel_d;
            cfg_start_q   <= cfg_start_d;
            cfg_reset_q   <= cfg_reset_d;
            axi_aresetn_q <= axi_aresetn_d;
            init_done_q   <= init_done_d;
            init_error_q  <= init_error_d;
        end
    end

    // Next state, counter, retry count, and the output pattern of the next state.
    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        cnt_d         = cnt_q;
        timeout       = 1'b0;
        pll_rstn_d    = 1'b0;
        phy_rstn_d    = 1'b0;
        ctrl_rstn_d   = 1'b0;
        cfg_sel_d     = 1'b0;
        cfg_start_d   = 1'b0;
        cfg_reset_d   = 1'b0;
        axi_aresetn_d = 1'b0;
        init_done_d   = 1'b0;
        init_error_d  = 1'b0;

        case (state_q)
            IDLE:     if (AUTO_START) state_d = PLL_RST;
            PLL_RST:  if (cnt_q == PLL_RST_LAST) state_d = PLL_WAIT;
            PLL_WAIT: begin
                if (lock_s)                  state_d = CFG_RST;
                else if (cnt_q == LOCK_LAST) timeout = 1'b1;
            end
            CFG_RST:  if (cnt_q == CFG_RST_LAST) state_d = CFG_RUN;
            CFG_RUN: begin
                if (done_s)                 state_d = AXI_REL;
                else if (cnt_q == CFG_LAST) timeout = 1'b1;
            end
            AXI_REL:  if (cnt_q == AXI_LAST) state_d = READY;
            READY:    if (!lock_s) state_d = PLL_RST;
            FAIL:     state_d = FAIL;
            default:  state_d = IDLE;
        endcase

        if (timeout) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = (retry_q == 2'b11) ? retry_q : retry_q + 2'd1;
                state_d = PLL_RST;
            end else begin
                state_d = FAIL;
            end
        end

        // start wins over everything, including a timeout in the same cycle.
        if (bus.start) begin
            state_d = PLL_RST;
            retry_d = 2'd0;
        end

        // A start re-entering PLL_RST counts as a fresh entry.
        if ((state_d != state_q) || bus.start) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_d)
            PLL_WAIT: pll_rstn_d = 1'b1;
            CFG_RST: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
                cfg_sel_d   = 1'b1;
                cfg_reset_d = 1'b1;
            end
            CFG_RUN: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
                cfg_sel_d   = 1'b1;
                cfg_start_d = 1'b1;
            end
            AXI_REL: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
            end
            READY: begin
                pll_rstn_d    = 1'b1;
                phy_rstn_d    = 1'b1;
                ctrl_rstn_d   = 1'b1;
                axi_aresetn_d = 1'b1;
                init_done_d   = 1'b1;
            end
            FAIL:    init_error_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.ddr_pll_rstn = pll_rstn_q;
    assign bus.phy_rstn     = phy_rstn_q;
    assign bus.ctrl_rstn    = ctrl_rstn_q;
    assign bus.cfg_sel      = cfg_sel_q;
    assign bus.cfg_start    = cfg_start_q;
    assign bus.cfg_reset    = cfg_reset_q;
    assign bus.axi_aresetn  = axi_aresetn_q;
    assign bus.init_done    = init_done_q;
    assign bus.init_error   = init_error_q;
    assign bus.state        = state_q;
    assign bus.retry_cnt    = retry_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq: directed scenarios followed by randomized lock/done/start/reset
// traffic, with every cycle compared against a behavioural model of the sequencer.
module tb_ddr_init_seq;

    localparam int unsigned P_PLL   = 4;
    localparam int unsigned P_LOCK  = 16;
    localparam int unsigned P_CRST  = 3;
    localparam int unsigned P_CTO   = 32;
    localparam int unsigned P_AXI   = 2;
    localparam int unsigned P_RETRY = 2;

    localparam logic [2:0] S_IDLE = 3'd0, S_PRST = 3'd1, S_PWAIT = 3'd2, S_CRUN = 3'd4;
    localparam logic [2:0] S_READY = 3'd6, S_FAIL = 3'd7;

    logic clk_100 = 1'b0;
    logic reset   = 1'b1;

    ddr_init_seq_if bus();

    ddr_init_seq #(
        .PLL_RST_CYC (P_PLL),
        .LOCK_TIMEOUT(P_LOCK),
        .CFG_RST_CYC (P_CRST),
        .CFG_TIMEOUT (P_CTO),
        .AXI_REL_CYC (P_AXI),
        .MAX_RETRY   (P_RETRY),
        .AUTO_START  (1'b1),
        .CNT_W       (16)
    ) dut (
        .clk_100(clk_100),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_100 = ~clk_100;

    int n_checks = 0;
    int n_fail   = 0;

    // {pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset, axi_aresetn, init_done, init_error}
    logic [8:0] dut_outs;
    assign dut_outs = {bus.ddr_pll_rstn, bus.phy_rstn, bus.ctrl_rstn, bus.cfg_sel, bus.cfg_start,
                       bus.cfg_reset, bus.axi_aresetn, bus.init_done, bus.init_error};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output pattern of each state, straight from the per-state output table.
    function automatic logic [8:0] exp_outs(input int s);
        case (s)
            2:       return 9'b100000000;
            3:       return 9'b111101000;
            4:       return 9'b111110000;
            5:       return 9'b111000000;
            6:       return 9'b111000110;
            7:       return 9'b000000001;
            default: return 9'b000000000;
        endcase
    endfunction

    // Fixed-length states advance to the next encoding after this many cycles.
    function automatic int fixed_len(input int s);
        case (s)
            1:       return int'(P_PLL);
            3:       return int'(P_CRST);
            5:       return int'(P_AXI);
            default: return 0;
        endcase
    endfunction

    // Waiting states give up after this many cycles.
    function automatic int wait_limit(input int s);
        case (s)
            2:       return int'(P_LOCK);
            4:       return int'(P_CTO);
            default: return 0;
        endcase
    endfunction

    int         m_state = 0;
    int         m_age   = 0;   // cycles already completed in the current state
    int         m_retry = 0;
    logic [1:0] lock_hist = '0; // input values seen at the last two edges
    logic [1:0] done_hist = '0;

    initial begin : model
        forever begin
            @(posedge clk_100 or posedge reset);
            if (reset) begin
                m_state   = 0;
                m_age     = 0;
                m_retry   = 0;
                lock_hist = '0;
                done_hist = '0;
            end else begin : step
                int nxt;
                int nretry;
                bit lock_seen;
                bit done_seen;
                lock_seen = lock_hist[1];
                done_seen = done_hist[1];
                lock_hist = {lock_hist[0], bus.ddr_pll_lock};
                done_hist = {done_hist[0], bus.cfg_done};
                nxt    = m_state;
                nretry = m_retry;
                if (m_state == 0) nxt = 1;
                if (fixed_len(m_state) != 0 && m_age + 1 >= fixed_len(m_state)) nxt = m_state + 1;
                if (m_state == 2 && lock_seen) nxt = 3;
                if (m_state == 4 && done_seen) nxt = 5;
                if (m_state == 6 && !lock_seen) nxt = 1;
                if (nxt == m_state && wait_limit(m_state) != 0 && m_age + 1 >= wait_limit(m_state)) begin
                    if (m_retry < int'(P_RETRY)) begin
                        nretry = m_retry + 1;
                        nxt    = 1;
                    end else begin
                        nxt = 7;
                    end
                end
                if (bus.start) begin
                    nxt    = 1;
                    nretry = 0;
                end
                m_age   = (nxt != m_state || bus.start) ? 0 : m_age + 1;
                m_state = nxt;
                m_retry = nretry;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_100) begin
        check("state", 32'(bus.state), 32'(m_state));
        check("outs", 32'(dut_outs), 32'(exp_outs(m_state)));
        check("retry", 32'(bus.retry_cnt), 32'(m_retry));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge clk_100);
            n++;
        end
        if (bus.state !== s) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out waiting, state %0d required %0d", name, bus.state, s);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_100);
        bus.start = 1'b1;
        @(negedge clk_100);
        bus.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         cyc, pll_low, crst_hi, fall_idx, rise_idx, since, entries, n;
        logic       prev_start;
        logic [2:0] prev_state;

        bus.start        = 1'b0;
        bus.ddr_pll_lock = 1'b0;
        bus.cfg_done     = 1'b0;
        reset            = 1'b1;
        repeat (3) @(negedge clk_100);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_outs", 32'(dut_outs), 32'd0);
        check("rst_retry", 32'(bus.retry_cnt), 32'd0);
        #2 reset = 1'b0;

        // Nominal run: lock 10 cycles into PLL_WAIT, cfg_done 20 cycles into CFG_RUN.
        cyc = 0; pll_low = 0; crst_hi = 0; fall_idx = -1; rise_idx = -1; since = 0;
        prev_start = 1'b0; prev_state = S_IDLE;
        while (bus.state != S_READY && cyc < 400) begin
            @(negedge clk_100);
            cyc++;
            if (!bus.ddr_pll_rstn) pll_low++;
            if (bus.cfg_reset) crst_hi++;
            if (prev_start && !bus.cfg_start && fall_idx < 0) fall_idx = cyc;
            if (bus.axi_aresetn && rise_idx < 0) rise_idx = cyc;
            prev_start = bus.cfg_start;
            if (bus.state != prev_state) since = 0; else since++;
            prev_state = bus.state;
            if (bus.state == S_PWAIT && since == 10) bus.ddr_pll_lock = 1'b1;
            if (bus.state == S_CRUN && since == 20) bus.cfg_done = 1'b1;
        end
        check("nom_pll_low", 32'(pll_low), 32'd4);
        check("nom_cfg_reset_hi", 32'(crst_hi), 32'd3);
        check("nom_axi_gap", 32'(rise_idx - fall_idx), 32'd2);
        check("nom_state", 32'(bus.state), 32'd6);
        check("nom_init_done", 32'(bus.init_done), 32'd1);
        check("nom_retry", 32'(bus.retry_cnt), 32'd0);

        // Lock dropped for 5 cycles in READY.
        @(negedge clk_100);
        bus.ddr_pll_lock = 1'b0;
        bus.cfg_done     = 1'b0;
        repeat (3) @(negedge clk_100);
        check("drop_state", 32'(bus.state), 32'd1);
        check("drop_axi", 32'(bus.axi_aresetn), 32'd0);
        check("drop_init_done", 32'(bus.init_done), 32'd0);
        repeat (2) @(negedge clk_100);
        bus.ddr_pll_lock = 1'b1;
        wait_state(S_CRUN, 100, "drop_cfg_run");
        bus.cfg_done = 1'b1;
        wait_state(S_READY, 100, "drop_ready");
        check("drop_retry", 32'(bus.retry_cnt), 32'd0);

        // cfg_done withheld on the first attempt, given on the second.
        bus.cfg_done = 1'b0;
        pulse_start();
        wait_state(S_CRUN, 100, "cto_cfg_run1");
        wait_state(S_PRST, 100, "cto_retry_rst");
        check("cto_retry_after_timeout", 32'(bus.retry_cnt), 32'd1);
        wait_state(S_CRUN, 100, "cto_cfg_run2");
        bus.cfg_done = 1'b1;
        wait_state(S_READY, 100, "cto_ready");
        check("cto_retry", 32'(bus.retry_cnt), 32'd1);
        check("cto_init_done", 32'(bus.init_done), 32'd1);

        // Lock never rises: three PLL_RST entries, then FAIL.
        bus.ddr_pll_lock = 1'b0;
        bus.cfg_done     = 1'b0;
        pulse_start();
        entries = (bus.state == S_PRST) ? 1 : 0;
        prev_state = bus.state;
        n = 0;
        while (bus.state != S_FAIL && n < 400) begin
            @(negedge clk_100);
            n++;
            if (bus.state == S_PRST && prev_state != S_PRST) entries++;
            prev_state = bus.state;
        end
        check("lock_fail_state", 32'(bus.state), 32'd7);
        check("lock_pll_rst_entries", 32'(entries), 32'd3);
        check("lock_init_error", 32'(bus.init_error), 32'd1);
        check("lock_retry", 32'(bus.retry_cnt), 32'd2);
        repeat (5) @(negedge clk_100);
        check("fail_hold", 32'(bus.state), 32'd7);
        pulse_start();
        check("fail_start_state", 32'(bus.state), 32'd1);
        check("fail_start_retry", 32'(bus.retry_cnt), 32'd0);

        // start coinciding with the final PLL_WAIT timeout at retry_cnt=2.
        n = 0;
        while (!(bus.state == S_PWAIT && bus.retry_cnt == 2'd2) && n < 400) begin
            @(negedge clk_100);
            n++;
        end
        check("coll_setup", 32'({bus.state, bus.retry_cnt}), 32'h0A);
        repeat (P_LOCK - 1) @(negedge clk_100);
        bus.start = 1'b1;
        @(negedge clk_100);
        bus.start = 1'b0;
        check("coll_state", 32'(bus.state), 32'd1);
        check("coll_retry", 32'(bus.retry_cnt), 32'd0);

        // Reset in the middle of CFG_RUN.
        bus.ddr_pll_lock = 1'b1;
        bus.cfg_done     = 1'b0;
        wait_state(S_CRUN, 100, "mid_cfg_run");
        repeat (3) @(negedge clk_100);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cfg_start", 32'(bus.cfg_start), 32'd0);
        check("mid_rst_rstn", 32'({bus.ddr_pll_rstn, bus.phy_rstn, bus.ctrl_rstn, bus.axi_aresetn}), 32'd0);
        check("mid_rst_state", 32'(bus.state), 32'd0);
        repeat (2) @(negedge clk_100);
        #2 reset = 1'b0;
        wait_state(S_CRUN, 100, "rerun_cfg_run");
        bus.cfg_done = 1'b1;
        wait_state(S_READY, 100, "rerun_ready");
        check("rerun_init_done", 32'(bus.init_done), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk_100);
            if (reset) begin
                if ($urandom_range(2) == 0) #2 reset = 1'b0;
            end else if ($urandom_range(499) == 0) begin
                #2 reset = 1'b1;
            end
            bus.start = bus.start ? 1'b0 : ($urandom_range(149) == 0);
            if (bus.ddr_pll_lock) begin
                if ($urandom_range(59) == 0) bus.ddr_pll_lock = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                bus.ddr_pll_lock = 1'b1;
            end
            if (bus.cfg_done) begin
                if ($urandom_range(39) == 0) bus.cfg_done = 1'b0;
            end else if ($urandom_range(14) == 0) begin
                bus.cfg_done = 1'b1;
            end
        end
        @(negedge clk_100);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk_100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
